// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven sequencer for a single board LED.
// Modes: OFF, steady ON, continuous BLINK, or a finite BURST of flashes
// followed by an LED-off gap. All timing comes from an internal
// millisecond prescaler running off sys_clk.
//
// Command handshake: a command transfers on a rising sys_clk edge when
// cmd_valid && cmd_ready && !abort. cmd_ready is a pure decode of the state
// and does not depend on cmd_valid. The driver holds the command fields
// stable while cmd_valid is high.
//
// Optional build macro LED_SEQ_STATS_EN adds burst_cnt, a saturating count
// of completed BURST commands.
//
// The FSM state is held in state_q (type state_t) so checkers can bind to it.
module led_seq_ctrl #(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int PERIOD_W    = 16,
  parameter int COUNT_W     = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_half_ms,
  input  logic [COUNT_W-1:0]  cmd_count,
  input  logic [PERIOD_W-1:0] cmd_gap_ms,
  input  logic                abort,
  output logic                led,
  output logic                busy,
  output logic                done
`ifdef LED_SEQ_STATS_EN
  ,
  output logic [15:0]         burst_cnt
`endif
);

  localparam int PRESC_MAX = CLK_FREQ_HZ / 1000 - 1;
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(PRESC_MAX);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEADY = 3'd1,
    S_PH_ON  = 3'd2,
    S_PH_OFF = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [COUNT_W-1:0]  flash_q, flash_d;
  logic [1:0]          mode_q, mode_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic                led_q, led_d;
  logic                done_q, done_d;

  logic                tick;
  logic                accept;
  logic [PERIOD_W-1:0] half_last;
  logic [PERIOD_W-1:0] gap_last;
  logic [COUNT_W-1:0]  flash_inc;

  assign tick      = (presc_q == PRESC_TERM);
  assign accept    = cmd_valid && cmd_ready && !abort;
  // half_q is never 0 once latched (0 is stored as 1), so half_last cannot underflow in a phase state.
  assign half_last = half_q - PERIOD_W'(1);
  // GAP is only entered with gap_q >= 1.
  assign gap_last  = gap_q - PERIOD_W'(1);
  // flash_q stays below count_q while flashing, so this never wraps.
  assign flash_inc = flash_q + COUNT_W'(1);

  // Continuous modes may be pre-empted; a running BURST may not.
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_STEADY) ||
                     (((state_q == S_PH_ON) || (state_q == S_PH_OFF)) &&
                      (mode_q == MODE_BLINK));
  assign busy      = (state_q != S_IDLE);
  assign led       = led_q;
  assign done      = done_q;

  // Next-state, counters and latched command; abort > accept > tick.
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    phase_d = phase_q;
    flash_d = flash_q;
    mode_d  = mode_q;
    half_d  = half_q;
    count_d = count_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      presc_d = '0;
      phase_d = '0;
      flash_d = '0;
    end else if (accept) begin
      mode_d  = cmd_mode;
      half_d  = (cmd_half_ms == '0) ? PERIOD_W'(1) : cmd_half_ms;
      count_d = cmd_count;
      gap_d   = cmd_gap_ms;
      presc_d = '0;
      phase_d = '0;
      flash_d = '0;
      case (cmd_mode)
        MODE_OFF: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        MODE_ON:    state_d = S_STEADY;
        MODE_BLINK: state_d = S_PH_ON;
        default: begin
          if (cmd_count == '0) begin
            if (cmd_gap_ms == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            state_d = S_PH_ON;
          end
        end
      endcase
    end else if (tick) begin
      case (state_q)
        S_PH_ON: begin
          if (phase_q == half_last) begin
            state_d = S_PH_OFF;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PERIOD_W'(1);
          end
        end
        S_PH_OFF: begin
          if (phase_q == half_last) begin
            phase_d = '0;
            if (mode_q == MODE_BURST) begin
              flash_d = flash_inc;
              if (flash_inc == count_q) begin
                if (gap_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_GAP;
                end
              end else begin
                state_d = S_PH_ON;
              end
            end else begin
              state_d = S_PH_ON;
            end
          end else begin
            phase_d = phase_q + PERIOD_W'(1);
          end
        end
        S_GAP: begin
          if (phase_q == gap_last) begin
            state_d = S_IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_q + PERIOD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // LED is registered from the next state so it follows a command one cycle after accept.
  assign led_d = (state_d == S_STEADY) || (state_d == S_PH_ON);

  // State, counters, latched command and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      flash_q <= '0;
      mode_q  <= MODE_OFF;
      half_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

`ifdef LED_SEQ_STATS_EN
  // done_d fires for an OFF accept or a BURST completion; exclude the OFF case.
  logic burst_done;
  assign burst_done = done_d && !(accept && (cmd_mode == MODE_OFF));

  // Saturating count of completed bursts, cleared only by reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (burst_done && (burst_cnt != 16'hFFFF)) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl with a 10 kHz clock parameter (1 ms = 10 clocks).
// The reference model tracks the time elapsed since the last accepted
// command and derives the LED waveform, busy, cmd_ready and done from it.
module tb_led_seq_ctrl;

  localparam int PERIOD_W = 16;
  localparam int COUNT_W  = 8;
  localparam int CLK_HZ   = 10_000;
  localparam int MS       = CLK_HZ / 1000;

  // ---------------- clock / reset / DUT ----------------
  logic                sys_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic [1:0]          cmd_mode = 2'd0;
  logic [PERIOD_W-1:0] cmd_half_ms = '0;
  logic [COUNT_W-1:0]  cmd_count = '0;
  logic [PERIOD_W-1:0] cmd_gap_ms = '0;
  logic                abort = 1'b0;
  logic                cmd_ready, led, busy, done;
`ifdef LED_SEQ_STATS_EN
  logic [15:0]         burst_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  led_seq_ctrl #(
    .CLK_FREQ_HZ(CLK_HZ),
    .PERIOD_W(PERIOD_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode),
    .cmd_half_ms(cmd_half_ms),
    .cmd_count(cmd_count),
    .cmd_gap_ms(cmd_gap_ms),
    .abort(abort),
    .led(led),
    .busy(busy),
    .done(done)
`ifdef LED_SEQ_STATS_EN
    ,
    .burst_cnt(burst_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];   // {led, busy, cmd_ready, done}

  int ready_low_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy   = 0;
  int m_mode   = 0;
  int m_p      = MS;   // clocks per on/off half-period
  int m_cnt    = 0;
  int m_k      = 0;    // cycles elapsed since accept (0 = first cycle after)
  int m_end    = 0;    // BURST: cycle index at which it returns to idle
  int m_bursts = 0;

  task automatic model_reset();
    m_busy   = 0;
    m_mode   = 0;
    m_k      = 0;
    m_bursts = 0;
  endtask

  function automatic logic [3:0] model_outputs(input bit e_done);
    bit e_led;
    bit e_rdy;
    int per;
    per   = 2 * m_p;
    e_led = m_busy && ((m_mode == 1) ||
                       ((m_mode == 2) && ((m_k % per) < m_p)) ||
                       ((m_mode == 3) && (m_k < m_cnt * per) && ((m_k % per) < m_p)));
    e_rdy = !m_busy || (m_mode == 1) || (m_mode == 2);
    return {e_led, m_busy, e_rdy, e_done};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    bit rdy;
    bit acc;
    bit e_done;
    int half;
    e_done = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = !m_busy || (m_mode == 1) || (m_mode == 2);
      acc = cmd_valid && rdy && !abort;
      if (abort && m_busy) begin
        m_busy = 0;
      end else if (acc) begin
        m_mode = int'(cmd_mode);
        half   = (cmd_half_ms == 0) ? 1 : int'(cmd_half_ms);
        m_p    = half * MS;
        m_cnt  = int'(cmd_count);
        m_k    = 0;
        case (m_mode)
          0: begin m_busy = 0; e_done = 1; end
          1, 2: m_busy = 1;
          default: begin
            m_end = m_cnt * 2 * m_p + int'(cmd_gap_ms) * MS;
            if (m_end == 0) begin
              m_busy = 0;
              e_done = 1;
              if (m_bursts < 65535) m_bursts++;
            end else begin
              m_busy = 1;
            end
          end
        endcase
      end else if (m_busy) begin
        m_k++;
        if ((m_mode == 3) && (m_k == m_end)) begin
          m_busy = 0;
          e_done = 1;
          if (m_bursts < 65535) m_bursts++;
        end
      end
    end
    exp_q.push_back(model_outputs(e_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [3:0] e;
    @(posedge sys_clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("led", 32'(led), 32'(e[3]));
    check("busy", 32'(busy), 32'(e[2]));
    check("cmd_ready", 32'(cmd_ready), 32'(e[1]));
    check("done", 32'(done), 32'(e[0]));
`ifdef LED_SEQ_STATS_EN
    check("burst_cnt", 32'(burst_cnt), 32'(m_bursts));
`endif
    if (!cmd_ready) ready_low_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int mode, input int half, input int cnt, input int gap);
    cmd_valid   = 1'b1;
    cmd_mode    = 2'(mode);
    cmd_half_ms = PERIOD_W'(half);
    cmd_count   = COUNT_W'(cnt);
    cmd_gap_ms  = PERIOD_W'(gap);
    cycle();
    cmd_valid   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state while rst_n is held low.
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    idle(3);
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle(4);

    // ON then OFF.
    send(1, 1, 0, 0);
    idle(6);
    send(0, 0, 0, 0);
    idle(4);

    // BLINK half=2, pre-empted by ON in the middle of PH_OFF.
    send(2, 2, 0, 0);
    idle(70);
    done_cnt = 0;
    send(1, 0, 0, 0);
    idle(5);
    check("preempt_no_done", 32'(done_cnt), 32'd0);
    send(0, 0, 0, 0);
    idle(3);

    // BURST count=3, half=1, gap=5: 110 clocks not ready, one done.
    ready_low_cnt = 0;
    done_cnt = 0;
    send(3, 1, 3, 5);
    idle(120);
    check("burst_ready_low", 32'(ready_low_cnt), 32'd110);
    check("burst_done_cnt", 32'(done_cnt), 32'd1);

    // BURST count=0 gap=0: done the cycle after accept.
    send(3, 1, 0, 0);
    check("zero_burst_done", 32'(done), 32'd1);
    idle(3);

    // BURST count=0 with a gap, then half=0 treated as 1 ms.
    send(3, 2, 0, 3);
    idle(35);
    send(3, 0, 2, 1);
    idle(55);
    send(2, 0, 0, 0);
    idle(45);

    // Abort together with cmd_valid in the middle of a BURST.
    send(3, 2, 3, 2);
    idle(30);
    abort = 1'b1;
    done_cnt = 0;
    send(1, 1, 0, 0);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    idle(5);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Abort in IDLE blocks the command and changes nothing.
    abort = 1'b1;
    send(1, 1, 0, 0);
    abort = 1'b0;
    idle(3);

    // Asynchronous reset mid-BLINK, between clock edges.
    send(2, 1, 0, 0);
    idle(4);
    @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    model_reset();
    idle(2);
    @(negedge sys_clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready", 32'(cmd_ready), 32'd1);
    idle(2);

    // Randomised command stream with occasional aborts.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid   = ($urandom_range(0, 9) == 0);
      cmd_mode    = 2'($urandom_range(0, 3));
      cmd_half_ms = PERIOD_W'($urandom_range(0, 3));
      cmd_count   = COUNT_W'($urandom_range(0, 4));
      cmd_gap_ms  = PERIOD_W'($urandom_range(0, 3));
      abort       = ($urandom_range(0, 59) == 0);
      cycle();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencing controller for a single board LED; replaces free-running 1 s toggle logic.
- Accepts commands over a valid/ready interface: OFF, steady ON, continuous BLINK, or a finite BURST of flashes followed by a quiet gap.
- Internal millisecond prescaler derives all timing from the 200 MHz system clock.
- Sits between software/status logic and the LED pin.

Parameters:
- CLK_FREQ_HZ, 200_000_000, system clock frequency; prescaler terminal = CLK_FREQ_HZ/1000 - 1.
- PERIOD_W, 16, width of the ms timing fields.
- COUNT_W, 8, width of the burst flash count.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cmd_half_ms  in  PERIOD_W  on-time and off-time per flash, in ms; 0 treated as 1.
- cmd_count  in  COUNT_W  number of flashes in BURST.
- cmd_gap_ms  in  PERIOD_W  LED-off gap after the last BURST flash, in ms.
- abort  in  1  cancel any activity.
- led  out  1  LED drive, registered.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pulse at BURST completion, or at OFF acceptance.

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - state=IDLE, led=0, busy=0, done=0;
  - prescaler, phase and flash counters to 0.
  - cmd_ready decodes as 1 but commands are ignored while rst_n is low.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ/1000-1 and emits a 1-cycle tick at terminal.
  - Cleared on command accept, so the first phase is a full ms multiple.
- Accept:
  - Occurs when cmd_valid & cmd_ready & !abort.
  - Latches mode, half_ms, count and gap_ms.
  - led reflects the new mode on the cycle after accept (1-cycle latency).
- cmd_ready:
  - 1 in IDLE, STEADY, PH_ON/PH_OFF when the mode is BLINK.
  - 0 during BURST (PH_ON, PH_OFF, GAP).
  - A new command pre-empts continuous modes without a done pulse.
- States:
  - IDLE: led=0, busy=0.
  - STEADY: led=1; entered on an ON command.
  - PH_ON: led=1; phase ms counter counts ticks; at the tick where the counter = half-1, go to PH_OFF and clear the counter.
  - PH_OFF: led=0; same length as PH_ON.
    - At end in BLINK: go to PH_ON.
    - At end in BURST: increment flash counter; if flashes == count go to GAP (or to IDLE with done if gap_ms=0), else go to PH_ON.
  - GAP: led=0; after gap_ms ticks go to IDLE with done=1 for one cycle.
- OFF command: led=0, state=IDLE, done pulses on the cycle after accept.
- BURST with count=0:
  - Goes straight to GAP; LED never lights.
  - If gap_ms is also 0: IDLE plus done on the next cycle.
- abort:
  - Highest priority over accept and tick in the same cycle.
  - Next cycle: IDLE, led=0, counters cleared, no done.
  - No effect in IDLE.
- Simultaneous accept and tick: the accept wins and the tick is discarded.
- Counters are exactly sized and never wrap: phase compare ≤ 2^PERIOD_W-1, flash compare ≤ 2^COUNT_W-1.

Optional Feature:
- Macro: LED_SEQ_STATS_EN.
- Defined:
  - Adds output burst_cnt[15:0], counting completed BURST commands (increment on each BURST done pulse).
  - Saturates at 0xFFFF; abort does not increment; cleared only by rst_n.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use CLK_FREQ_HZ=10_000, so 1 ms = 10 clocks.
- Reset mid-BLINK (assert rst_n low asynchronously between clock edges) -> led=0, busy=0, done=0 immediately; cmd_ready=1 after release.
- ON then OFF: accept ON -> led=1 next cycle, busy=1; accept OFF -> led=0, done pulse exactly 1 cycle, busy=0.
- BLINK, half_ms=2 -> led high 20 clocks, low 20 clocks, repeating; cmd_ready stays 1; a new ON accepted mid-PH_OFF -> led=1 next cycle, no done.
- BURST, count=3, half_ms=1, gap_ms=5 -> three 10-clock high pulses separated by 10-clock lows, then 50-clock gap, then done; cmd_ready=0 for 110 clocks total.
- Edge fields:
  - BURST count=0, gap_ms=0 -> done the cycle after accept, led never 1.
  - half_ms=0 -> behaves as 1 ms.
- abort asserted together with cmd_valid in the middle of a BURST -> command not accepted, IDLE next cycle, no done; LED_SEQ_STATS_EN build: burst_cnt unchanged, and increments by 1 per completed burst otherwise.
